mem_arbiter: RTL

Two-port arbiter that shares the single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between the pipeline front ends and the memory model or bus bridge. It accepts one request at a time over valid/ready handshakes, forwards that request to memory, and returns the response to the requester that owns it. Only one transaction is in flight at any time.

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between the IFU (read-only) and the LSU (read/write).
// Only one transaction is in flight at a time. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DATA_W-1:0]   ifu_rsp_data,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DATA_W-1:0]   lsu_rsp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                mem_rsp_ready
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rspData_q, rspData_d;

    logic lsuPreferred;
    logic grantLsu;
    logic grantIfu;
    logic ownerTakesRsp;

`ifdef MEM_ARB_RR_EN
    owner_e last_q, last_d;

    // Under contention the requester that was not granted last time goes first.
    assign lsuPreferred = (last_q == OWN_IFU);
`else
    assign lsuPreferred = 1'b1;
`endif

    assign grantLsu = (state_q == IDLE) && lsu_req_valid && (!ifu_req_valid || lsuPreferred);
    assign grantIfu = (state_q == IDLE) && ifu_req_valid && !grantLsu;

    assign ownerTakesRsp = (owner_q == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IFU;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rspData_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q    <= OWN_IFU;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rspData_q <= rspData_d;
`ifdef MEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rspData_d = rspData_q;
`ifdef MEM_ARB_RR_EN
        last_d    = last_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (grantLsu) begin
                    owner_d = OWN_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wstrb_d = lsu_wstrb;
                    state_d = ISSUE;
`ifdef MEM_ARB_RR_EN
                    last_d  = OWN_LSU;
`endif
                end else if (grantIfu) begin
                    // Instruction fetches are always plain reads.
                    owner_d = OWN_IFU;
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wstrb_d = '0;
                    state_d = ISSUE;
`ifdef MEM_ARB_RR_EN
                    last_d  = OWN_IFU;
`endif
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rspData_d = wen_q ? '0 : mem_rsp_data;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (ownerTakesRsp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ifu_req_ready = grantIfu;
    assign lsu_req_ready = grantLsu;

    assign mem_req_valid = (state_q == ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign mem_rsp_ready = (state_q == WAIT);

    // Response data is only presented on the port of the requester that owns it.
    assign ifu_rsp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
    assign lsu_rsp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
    assign ifu_rsp_data  = (owner_q == OWN_IFU) ? rspData_q : '0;
    assign lsu_rsp_data  = (owner_q == OWN_LSU) ? rspData_q : '0;

endmodule
